// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if
//   Bundles the two requester ports (core load/store path and external
//   loader/debug port) and the single-port data-memory port of the arbiter.
//
//   Signals:
//     core_req/we/addr/wdata    core request (held until core_gnt)
//     core_gnt/stall            core grant and pipeline hold
//     core_rvalid/rdata         core load return
//     ext_req/we/addr/wdata     external request (held until ext_gnt)
//     ext_gnt                   external grant
//     ext_rvalid/rdata          external load return
//     mem_en/we/addr/wdata      memory command
//     mem_rdata                 memory read data, valid one cycle after a read
//
//   Modports:
//     slave  - the arbiter
//     master - whoever drives the requests and models the memory
interface dmem_arbiter_if #(
  parameter int AW = 8,
  parameter int DW = 8
);
  logic          core_req;
  logic          core_we;
  logic [AW-1:0] core_addr;
  logic [DW-1:0] core_wdata;
  logic          core_gnt;
  logic          core_stall;
  logic          core_rvalid;
  logic [DW-1:0] core_rdata;

  logic          ext_req;
  logic          ext_we;
  logic [AW-1:0] ext_addr;
  logic [DW-1:0] ext_wdata;
  logic          ext_gnt;
  logic          ext_rvalid;
  logic [DW-1:0] ext_rdata;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  core_req, core_we, core_addr, core_wdata,
    output core_gnt, core_stall, core_rvalid, core_rdata,
    input  ext_req, ext_we, ext_addr, ext_wdata,
    output ext_gnt, ext_rvalid, ext_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output core_req, core_we, core_addr, core_wdata,
    input  core_gnt, core_stall, core_rvalid, core_rdata,
    output ext_req, ext_we, ext_addr, ext_wdata,
    input  ext_gnt, ext_rvalid, ext_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Shares one single-port data memory between the core's load/store path
//   and an external loader/debug port. The core has priority; a saturating
//   starvation counter forces a grant to the external port after it has lost
//   STARVE_MAX consecutive arbitration cycles. Read data comes back one cycle
//   after the grant, steered to the requester that issued the read.
//
//   Ports:
//     clk  - system clock, rising edge
//     rst  - asynchronous, active-low reset
//     bus  - dmem_arbiter_if.slave (requester ports + memory port)
//
//   Parameters:
//     AW, DW      address / data width
//     STARVE_MAX  lost cycles before the external port is forced (>= 1)
module dmem_arbiter #(
  parameter int AW         = 8,
  parameter int DW         = 8,
  parameter int STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            rst,
  dmem_arbiter_if.slave   bus
);

  localparam int CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_MAX);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CORE = 2'd1,
    OWN_EXT  = 2'd2
  } owner_t;

  logic [CW-1:0] starve_cnt_reg;
  owner_t        rd_owner_reg;

  logic force_ext;
  logic core_gnt;
  logic ext_gnt;

  // Grants are gated by rst so nothing reaches memory while reset is held,
  // even though the requesters may keep their requests asserted.
  assign force_ext = bus.ext_req & (starve_cnt_reg == CNT_MAX);
  assign core_gnt  = rst & bus.core_req & ~force_ext;
  assign ext_gnt   = rst & bus.ext_req & (force_ext | ~bus.core_req);

  assign bus.core_gnt   = core_gnt;
  assign bus.ext_gnt    = ext_gnt;
  assign bus.core_stall = rst & bus.core_req & ~core_gnt;

  // Memory command mux; idle command is all zeros.
  always_comb begin
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (core_gnt) begin
      bus.mem_en    = 1'b1;
      bus.mem_we    = bus.core_we;
      bus.mem_addr  = bus.core_addr;
      bus.mem_wdata = bus.core_wdata;
    end else if (ext_gnt) begin
      bus.mem_en    = 1'b1;
      bus.mem_we    = bus.ext_we;
      bus.mem_addr  = bus.ext_addr;
      bus.mem_wdata = bus.ext_wdata;
    end
  end

  // Read return: the owner register records who issued last cycle's read.
  assign bus.core_rvalid = (rd_owner_reg == OWN_CORE);
  assign bus.ext_rvalid  = (rd_owner_reg == OWN_EXT);
  assign bus.core_rdata  = (rd_owner_reg == OWN_CORE) ? bus.mem_rdata : '0;
  assign bus.ext_rdata   = (rd_owner_reg == OWN_EXT)  ? bus.mem_rdata : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt_reg <= '0;
      rd_owner_reg   <= OWN_NONE;
    end else begin
      // A dropped external request forfeits its accumulated credit.
      if (ext_gnt || !bus.ext_req) begin
        starve_cnt_reg <= '0;
      end else if (starve_cnt_reg != CNT_MAX) begin
        starve_cnt_reg <= starve_cnt_reg + 1'b1;
      end

      if (core_gnt && !bus.core_we) begin
        rd_owner_reg <= OWN_CORE;
      end else if (ext_gnt && !bus.ext_we) begin
        rd_owner_reg <= OWN_EXT;
      end else begin
        rd_owner_reg <= OWN_NONE;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.AW(8), .DW(8)) bus ();

  dmem_arbiter #(.AW(8), .DW(8), .STARVE_MAX(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- memory model (driven only by the DUT's mem port) -------
  function automatic logic [7:0] init_val(input logic [7:0] a);
    case (a)
      8'h10:   return 8'hA5;
      8'h01:   return 8'h11;
      8'h02:   return 8'h22;
      default: return a ^ 8'hC3;
    endcase
  endfunction

  logic [7:0] mem [256];
  bit   [255:0] wr_flag;
  logic [7:0] rd_q = 8'h00;
  assign bus.mem_rdata = rd_q;

  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) begin
        mem[bus.mem_addr]     <= bus.mem_wdata;
        wr_flag[bus.mem_addr] <= 1'b1;
      end else begin
        rd_q <= wr_flag[bus.mem_addr] ? mem[bus.mem_addr] : init_val(bus.mem_addr);
      end
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [1:0] own;   // 1 = core, 2 = ext
    logic [7:0] data;
  } exp_t;

  exp_t       pending[$];
  logic [7:0] ref_mem [256];
  int         errors = 0;
  int         checks = 0;
  int         step_no = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    assert (act === exp) else begin
      errors++;
      $error("FAIL step %0d %s: got %0h expected %0h", step_no, name, act, exp);
    end
  endtask

  task automatic check_returns();
    exp_t e;
    logic cv, ev;
    logic [7:0] d;
    cv = 1'b0; ev = 1'b0; d = 8'h00;
    if (pending.size() > 0) begin
      e  = pending.pop_front();
      cv = (e.own == 2'd1);
      ev = (e.own == 2'd2);
      d  = e.data;
    end
    chk("core_rvalid", bus.core_rvalid, cv);
    chk("core_rdata",  bus.core_rdata,  cv ? d : 8'h00);
    chk("ext_rvalid",  bus.ext_rvalid,  ev);
    chk("ext_rdata",   bus.ext_rdata,   ev ? d : 8'h00);
  endtask

  // One clock cycle: check returns and grants at the falling edge, record
  // expected effects, optionally assert reset before the next rising edge.
  task automatic step(input bit ec, input bit ee, input bit es, input bit rst_after);
    @(negedge clk);
    step_no++;
    check_returns();
    chk("core_gnt",   bus.core_gnt,   ec);
    chk("ext_gnt",    bus.ext_gnt,    ee);
    chk("core_stall", bus.core_stall, es);
    chk("mem_en",     bus.mem_en,     ec | ee);
    if (ec) begin
      chk("mem_we",    bus.mem_we,    bus.core_we);
      chk("mem_addr",  bus.mem_addr,  bus.core_addr);
      chk("mem_wdata", bus.mem_wdata, bus.core_wdata);
      if (bus.core_we) ref_mem[bus.core_addr] = bus.core_wdata;
      else pending.push_back('{own: 2'd1, data: ref_mem[bus.core_addr]});
    end else if (ee) begin
      chk("mem_we",    bus.mem_we,    bus.ext_we);
      chk("mem_addr",  bus.mem_addr,  bus.ext_addr);
      chk("mem_wdata", bus.mem_wdata, bus.ext_wdata);
      if (bus.ext_we) ref_mem[bus.ext_addr] = bus.ext_wdata;
      else pending.push_back('{own: 2'd2, data: ref_mem[bus.ext_addr]});
    end else begin
      chk("mem_we",    bus.mem_we,    1'b0);
      chk("mem_addr",  bus.mem_addr,  8'h00);
      chk("mem_wdata", bus.mem_wdata, 8'h00);
    end
    $display("step %0d: rst=%0b core_gnt=%0b ext_gnt=%0b stall=%0b mem_en=%0b we=%0b addr=%02h wdata=%02h crv=%0b erv=%0b",
             step_no, rst, bus.core_gnt, bus.ext_gnt, bus.core_stall, bus.mem_en,
             bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.core_rvalid, bus.ext_rvalid);
    if (rst_after) begin
      #1 rst = 1'b0;
      pending.delete();   // the read in flight must be dropped
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_core(input bit req, input bit we, input logic [7:0] a, input logic [7:0] d);
    bus.core_req = req; bus.core_we = we; bus.core_addr = a; bus.core_wdata = d;
  endtask

  task automatic set_ext(input bit req, input bit we, input logic [7:0] a, input logic [7:0] d);
    bus.ext_req = req; bus.ext_we = we; bus.ext_addr = a; bus.ext_wdata = d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(8'(i));

    // Reset held with both requests pending: everything quiet.
    set_core(1, 0, 8'h05, 8'h00);
    set_ext (1, 0, 8'h06, 8'h00);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);

    // Release: core wins immediately, ext forced on the fifth cycle, twice.
    rst = 1'b1;
    repeat (4) step(1, 0, 0, 0);
    step(0, 1, 1, 0);
    repeat (4) step(1, 0, 0, 0);
    step(0, 1, 1, 0);
    set_core(0, 0, 8'h00, 8'h00);
    set_ext (0, 0, 8'h00, 8'h00);
    step(0, 0, 0, 0);

    // Core read of 0x10.
    set_core(1, 0, 8'h10, 8'h00);
    step(1, 0, 0, 0);
    set_core(0, 0, 8'h00, 8'h00);
    step(0, 0, 0, 0);

    // External write with idle core, then core reads it back.
    set_ext(1, 1, 8'h20, 8'h3C);
    step(0, 1, 0, 0);
    set_ext(0, 0, 8'h00, 8'h00);
    set_core(1, 0, 8'h20, 8'h00);
    step(1, 0, 0, 0);
    set_core(0, 0, 8'h00, 8'h00);
    step(0, 0, 0, 0);

    // Dropping ext_req forfeits the accumulated credit.
    set_core(1, 0, 8'h07, 8'h00);
    set_ext (1, 0, 8'h08, 8'h00);
    repeat (3) step(1, 0, 0, 0);
    bus.ext_req = 1'b0;
    step(1, 0, 0, 0);
    bus.ext_req = 1'b1;
    repeat (4) step(1, 0, 0, 0);
    step(0, 1, 1, 0);
    set_core(0, 0, 8'h00, 8'h00);
    set_ext (0, 0, 8'h00, 8'h00);
    step(0, 0, 0, 0);

    // Interleaved reads: core 0x01 then ext 0x02, back to back.
    set_core(1, 0, 8'h01, 8'h00);
    step(1, 0, 0, 0);
    set_core(0, 0, 8'h00, 8'h00);
    set_ext (1, 0, 8'h02, 8'h00);
    step(0, 1, 0, 0);
    set_ext (0, 0, 8'h00, 8'h00);
    step(0, 0, 0, 0);

    // Core write then external read of the same location.
    set_core(1, 1, 8'h30, 8'h77);
    step(1, 0, 0, 0);
    set_core(0, 0, 8'h00, 8'h00);
    set_ext (1, 0, 8'h30, 8'h00);
    step(0, 1, 0, 0);
    set_ext (0, 0, 8'h00, 8'h00);
    step(0, 0, 0, 0);

    // Reset during a core read: the return is dropped, arbitration restarts.
    set_core(1, 0, 8'h10, 8'h00);
    step(1, 0, 0, 1);
    step(0, 0, 0, 0);
    rst = 1'b1;
    set_ext(1, 0, 8'h06, 8'h00);
    repeat (4) step(1, 0, 0, 0);
    step(0, 1, 1, 0);
    set_core(0, 0, 8'h00, 8'h00);
    set_ext (0, 0, 8'h00, 8'h00);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter that shares the processor's single-port, 8-bit data memory between the core's load/store path and an external loader/debug port. It sits between `top`'s memory stage (ALUOut as address, rd2_Data as store data, MemWrite as write strobe) and the data memory. Core accesses have priority, and a starvation counter guarantees forward progress for the external port. Read data is returned one cycle after the grant, tagged to the requester that issued the read.

## Interface
- AW, 8, address width
- DW, 8, data width
- STARVE_MAX, 4, consecutive lost arbitration cycles before the external port is forced a grant (≥1)

- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- core_req  in  1  core memory request (held until granted)
- core_we  in  1  1 = store, 0 = load
- core_addr  in  AW  core address (ALUOut)
- core_wdata  in  DW  core store data (rd2_Data)
- core_gnt  out  1  core request accepted this cycle
- core_stall  out  1  core_req & ~core_gnt; feeds PC/pipeline hold
- core_rvalid  out  1  core load data valid
- core_rdata  out  DW  core load data
- ext_req, ext_we, ext_addr, ext_wdata  in  1/1/AW/DW  external port request, same semantics as core
- ext_gnt  out  1  external request accepted
- ext_rvalid  out  1  external load data valid
- ext_rdata  out  DW  external load data
- mem_en  out  1  memory access enable
- mem_we  out  1  memory write enable
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data, valid the cycle after mem_en & ~mem_we

## Operation
- State: starve_cnt (range 0..STARVE_MAX, saturating) and rd_owner (NONE/CORE/EXT) for the read issued in the previous cycle.
- Grant (combinational, same cycle as request):
  - force_ext = ext_req & (starve_cnt == STARVE_MAX)
  - ext_gnt = ext_req & (force_ext | ~core_req)
  - core_gnt = core_req & ~force_ext
  - At most one grant per cycle.
- While rst is low, both grants are 0 and mem_en is 0.
- Mux: mem_en = core_gnt | ext_gnt. mem_we, mem_addr and mem_wdata come from the granted requester. They are 0 when there is no grant.
- starve_cnt update at each clock edge:
  - ext_gnt → 0
  - ext_req & ~ext_gnt → min(cnt+1, STARVE_MAX)
  - ~ext_req → 0. A dropped request forfeits accumulated credit.
- rd_owner update at each clock edge:
  - CORE if core_gnt & ~core_we
  - EXT if ext_gnt & ~ext_we
  - otherwise NONE
- Read return:
  - core_rvalid = (rd_owner == CORE); ext_rvalid = (rd_owner == EXT)
  - Both rdata outputs carry mem_rdata when their rvalid is 1, and 0 otherwise.
- Writes produce no rvalid.

## Timing
- Reset values:
  - starve_cnt = 0, rd_owner = NONE
  - all grants, rvalids and rdata = 0
  - mem_en, mem_we, mem_addr, mem_wdata = 0
  - core_stall = 0
- Latency:
  - Grant is 0 cycles after request.
  - A write commits at the clock edge that ends the grant cycle.
  - Read data returns with rvalid exactly 1 cycle after the grant. Back-to-back reads give one result per cycle.
- Handshake: a requester holds req, we, addr and wdata stable until it sees gnt. It may change them in the cycle after gnt.
- Boundary conditions:
  - **Simultaneous requests, cnt < STARVE_MAX:** core wins and cnt increments.
  - **Simultaneous requests, cnt = STARVE_MAX:** ext wins, core_stall = 1 for that cycle, and cnt clears.
  - **Saturation:** cnt never exceeds STARVE_MAX.
  - **Reset mid-read:** a pending rvalid is dropped and does not appear after rst deasserts.
  - **First cycle after deassertion:** arbitration restarts from cnt = 0.
- Worst-case external wait with continuous core traffic: STARVE_MAX + 1 cycles from ext_req to ext_gnt.

## Test plan
- **Reset:** hold rst=0 with both reqs=1 → all outputs 0. Release rst → core_gnt=1 in the same cycle and mem_addr=core_addr.
- **Core read:** mem[0x10]=0xA5, core_req=1, core_we=0, core_addr=0x10 → core_gnt=1, mem_en=1, mem_we=0. Next cycle core_rvalid=1, core_rdata=0xA5, ext_rvalid=0.
- **External write with idle core:** ext_req=1, ext_we=1, ext_addr=0x20, ext_wdata=0x3C, core_req=0 → ext_gnt=1, mem_we=1, mem_wdata=0x3C. A subsequent core read of 0x20 returns 0x3C.
- **Starvation (STARVE_MAX=4):** core_req and ext_req held at 1 continuously → core_gnt for cycles 0-3, ext_gnt in cycle 4 with core_stall=1, then core_gnt again from cycle 5 with cnt=0.
- **Interleaved reads:** core read of 0x01 (=0x11) in cycle N, external read of 0x02 (=0x22) in cycle N+1 → core_rvalid/0x11 in N+1, ext_rvalid/0x22 in N+2, never both valid together.
- **Reset mid-operation:** core read granted in cycle N, rst pulled low before edge N+1 → core_rvalid stays 0 through and after reset, and starve_cnt=0.
